// File: rtl/usb_rx_packet.sv
// USB receive packet engine: PID check, CRC16 check, payload forwarding with the two CRC bytes held back.
// Payload byte n leaves one cycle after byte n+2 arrives and pkt_done follows rx_active low by one cycle; there is no backpressure.
module usb_rx_packet #(
    parameter int MAX_BYTES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_active,
    input  logic        rx_valid,
    input  logic        rx_error,
    input  logic [7:0]  rx_data,
    output logic [3:0]  pid,
    output logic        pid_valid,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic [10:0] byte_count,
    output logic        busy,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic        err_pid,
    output logic        err_crc,
    output logic        err_len,
    output logic        err_rx
);

    typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_ABORT, S_DONE} state_t;

    localparam logic [10:0] LP_MAX = 11'(MAX_BYTES);

    state_t      r_state;
    logic [15:0] r_crc;
    logic [7:0]  r_hb0;
    logic [7:0]  r_hb1;
    logic [1:0]  r_hb_cnt;
    logic        r_is_data;
    logic        r_err_pid;
    logic        r_err_len;
    logic        r_err_rx;

    logic        w_pid_ok;
    logic        w_in_pkt;
    logic        w_fin_pid;
    logic        w_fin_len;
    logic        w_fin_crc;
    logic [15:0] w_crc_next;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            x = x[0] ? ((x >> 1) ^ 16'hA001) : (x >> 1);
        end
        return x;
    endfunction

    // Only data (xx11) and handshake (xx10) PIDs are accepted.
    assign w_pid_ok   = (rx_data[7:4] == ~rx_data[3:0]) && rx_data[1];
    assign w_crc_next = crc_byte(r_crc, rx_data);
    assign w_in_pkt   = (r_state == S_PID) || (r_state == S_DATA) || (r_state == S_ABORT);
    assign w_fin_pid  = r_err_pid || (r_state == S_PID);
    assign w_fin_len  = r_err_len || ((r_state == S_DATA) && r_is_data && (r_hb_cnt != 2'd2));
    assign w_fin_crc  = (r_state == S_DATA) && r_is_data && (r_hb_cnt == 2'd2) && (r_crc != 16'hB001);
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_crc      <= 16'hFFFF;
            r_hb0      <= 8'h00;
            r_hb1      <= 8'h00;
            r_hb_cnt   <= 2'd0;
            r_is_data  <= 1'b0;
            r_err_pid  <= 1'b0;
            r_err_len  <= 1'b0;
            r_err_rx   <= 1'b0;
            pid        <= 4'h0;
            pid_valid  <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            byte_count <= 11'd0;
            pkt_done   <= 1'b0;
            pkt_ok     <= 1'b0;
            err_pid    <= 1'b0;
            err_crc    <= 1'b0;
            err_len    <= 1'b0;
            err_rx     <= 1'b0;
        end else begin
            pid_valid  <= 1'b0;
            data_valid <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_ok     <= 1'b0;
            err_pid    <= 1'b0;
            err_crc    <= 1'b0;
            err_len    <= 1'b0;
            err_rx     <= 1'b0;

            if (w_in_pkt && !rx_active) begin
                // End of packet from any active state; holdback contents are the CRC and are dropped.
                pkt_done <= 1'b1;
                err_pid  <= w_fin_pid;
                err_len  <= w_fin_len;
                err_crc  <= w_fin_crc;
                err_rx   <= r_err_rx;
                pkt_ok   <= ~(w_fin_pid | w_fin_len | w_fin_crc | r_err_rx);
                r_state  <= S_DONE;
            end else if (((r_state == S_PID) || (r_state == S_DATA)) && rx_error) begin
                r_err_rx <= 1'b1;
                r_state  <= S_ABORT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_active) begin
                            r_state <= S_PID;
                        end
                    end
                    S_PID: begin
                        if (rx_valid) begin
                            byte_count <= 11'd0;
                            if (w_pid_ok) begin
                                pid       <= rx_data[3:0];
                                pid_valid <= 1'b1;
                                r_is_data <= rx_data[0];
                                r_state   <= S_DATA;
                            end else begin
                                r_err_pid <= 1'b1;
                                r_state   <= S_ABORT;
                            end
                        end
                    end
                    S_DATA: begin
                        if (rx_valid) begin
                            r_crc <= w_crc_next;
                            if (!r_is_data) begin
                                r_err_len <= 1'b1;
                            end
                            if (r_hb_cnt != 2'd2) begin
                                if (r_hb_cnt == 2'd0) begin
                                    r_hb0 <= rx_data;
                                end else begin
                                    r_hb1 <= rx_data;
                                end
                                r_hb_cnt <= r_hb_cnt + 2'd1;
                            end else begin
                                if (r_is_data) begin
                                    if (byte_count >= LP_MAX) begin
                                        r_err_len <= 1'b1;
                                    end else begin
                                        data_out   <= r_hb0;
                                        data_valid <= 1'b1;
                                        if (byte_count != 11'h7FF) begin
                                            byte_count <= byte_count + 11'd1;
                                        end
                                    end
                                end
                                r_hb0 <= r_hb1;
                                r_hb1 <= rx_data;
                            end
                        end
                    end
                    S_ABORT: begin
                        r_state <= S_ABORT;
                    end
                    S_DONE: begin
                        r_state   <= S_IDLE;
                        r_crc     <= 16'hFFFF;
                        r_hb_cnt  <= 2'd0;
                        r_is_data <= 1'b0;
                        r_err_pid <= 1'b0;
                        r_err_len <= 1'b0;
                        r_err_rx  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_packet.sv
// Directed bench for usb_rx_packet: hand-built packets with expected pid, payload, counts and status flags.
module tb_usb_rx_packet;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_active;
    logic        rx_valid;
    logic        rx_error;
    logic [7:0]  rx_data;
    logic [3:0]  pid;
    logic        pid_valid;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [10:0] byte_count;
    logic        busy;
    logic        pkt_done;
    logic        pkt_ok;
    logic        err_pid;
    logic        err_crc;
    logic        err_len;
    logic        err_rx;

    usb_rx_packet dut (
        .clk        (clk),
        .reset      (reset),
        .rx_active  (rx_active),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .rx_data    (rx_data),
        .pid        (pid),
        .pid_valid  (pid_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .byte_count (byte_count),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .pkt_ok     (pkt_ok),
        .err_pid    (err_pid),
        .err_crc    (err_crc),
        .err_len    (err_len),
        .err_rx     (err_rx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor: records pulses and end-of-packet status on the falling edge.
    int         dv_cnt   = 0;
    int         pv_cnt   = 0;
    int         done_cnt = 0;
    logic [7:0] cap [0:4095];
    logic       f_ok, f_epid, f_ecrc, f_elen, f_erx;
    logic [3:0] f_pid;
    int         f_bc;

    always @(negedge clk) begin
        if (data_valid) begin
            cap[dv_cnt % 4096] <= data_out;
            dv_cnt <= dv_cnt + 1;
        end
        if (pid_valid) begin
            pv_cnt <= pv_cnt + 1;
        end
        if (pkt_done) begin
            done_cnt <= done_cnt + 1;
            f_ok     <= pkt_ok;
            f_epid   <= err_pid;
            f_ecrc   <= err_crc;
            f_elen   <= err_len;
            f_erx    <= err_rx;
            f_pid    <= pid;
            f_bc     <= int'(byte_count);
        end
    end

    logic [7:0] txq[$];
    int b_dv, b_pv, b_done;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic snap();
        b_dv   = dv_cnt;
        b_pv   = pv_cnt;
        b_done = done_cnt;
    endtask

    task automatic start_pkt();
        snap();
        rx_active = 1'b1;
        tick();
        chk("busy_in_pkt", int'(busy), 1);
    endtask

    task automatic finish_pkt();
        rx_active = 1'b0;
        for (int i = 0; i < 8 && done_cnt == b_done; i++) begin
            tick();
        end
        chk("pkt_done_seen", done_cnt - b_done, 1);
        tick();
        tick();
    endtask

    task automatic run_pkt();
        start_pkt();
        foreach (txq[i]) send(txq[i]);
        finish_pkt();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        rx_active = 1'b0;
        rx_valid  = 1'b0;
        rx_error  = 1'b0;
        rx_data   = 8'h00;
        repeat (3) tick();
        chk("rst_pid", int'(pid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_byte_count", int'(byte_count), 0);
        chk("rst_pulses", int'({pid_valid, data_valid, pkt_done, pkt_ok}), 0);
        chk("rst_errs", int'({err_pid, err_crc, err_len, err_rx}), 0);
        reset = 1'b1;
        tick();

        // rx_valid without rx_active is ignored
        snap();
        send(8'hC3);
        tick();
        chk("idle_ignore_busy", int'(busy), 0);
        chk("idle_ignore_pv", pv_cnt - b_pv, 0);

        // Empty DATA0
        txq = '{8'hC3, 8'h00, 8'h00};
        run_pkt();
        chk("d0_pid_valid", pv_cnt - b_pv, 1);
        chk("d0_pid", int'(f_pid), 3);
        chk("d0_no_data", dv_cnt - b_dv, 0);
        chk("d0_byte_count", f_bc, 0);
        chk("d0_ok", int'(f_ok), 1);

        // DATA1 "123456789" with CRC B4C8
        txq = '{8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        run_pkt();
        chk("d1_pid", int'(f_pid), 4'hB);
        chk("d1_count", dv_cnt - b_dv, 9);
        for (int i = 0; i < 9; i++) chk("d1_payload", int'(cap[(b_dv + i) % 4096]), 8'h31 + i);
        chk("d1_byte_count", f_bc, 9);
        chk("d1_ok", int'(f_ok), 1);
        chk("d1_err_crc", int'(f_ecrc), 0);

        // Same packet, corrupted last CRC byte
        txq = '{8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB5};
        run_pkt();
        chk("crcbad_count", dv_cnt - b_dv, 9);
        chk("crcbad_err_crc", int'(f_ecrc), 1);
        chk("crcbad_ok", int'(f_ok), 0);

        // PID A5 (SOF type) rejected
        txq = '{8'hA5, 8'h12, 8'h34};
        run_pkt();
        chk("badpid_pv", pv_cnt - b_pv, 0);
        chk("badpid_data", dv_cnt - b_dv, 0);
        chk("badpid_err", int'(f_epid), 1);
        chk("badpid_ok", int'(f_ok), 0);

        // ACK alone, then ACK with a trailing byte
        txq = '{8'hD2};
        run_pkt();
        chk("ack_pid", int'(f_pid), 2);
        chk("ack_ok", int'(f_ok), 1);
        txq = '{8'hD2, 8'h00};
        run_pkt();
        chk("ack_len_err", int'(f_elen), 1);
        chk("ack_len_ok", int'(f_ok), 0);
        chk("ack_len_data", dv_cnt - b_dv, 0);

        // DATA0 with only one byte after PID
        txq = '{8'hC3, 8'h00};
        run_pkt();
        chk("short_len_err", int'(f_elen), 1);
        chk("short_crc_err", int'(f_ecrc), 0);

        // rx_active drops before any PID byte
        start_pkt();
        tick();
        finish_pkt();
        chk("nopid_err", int'(f_epid), 1);
        chk("nopid_pv", pv_cnt - b_pv, 0);

        // rx_error after 4 payload bytes; later bytes ignored in abort
        start_pkt();
        send(8'h4B);
        send(8'h31);
        send(8'h32);
        send(8'h33);
        send(8'h34);
        rx_error = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h35;
        tick();
        rx_error = 1'b0;
        rx_valid = 1'b0;
        send(8'h36);
        send(8'h37);
        tick();
        finish_pkt();
        chk("rxerr_data", dv_cnt - b_dv, 2);
        chk("rxerr_flag", int'(f_erx), 1);
        chk("rxerr_ok", int'(f_ok), 0);
        chk("rxerr_byte_count", f_bc, 2);

        // Reset mid-packet: no pkt_done, then a clean packet
        start_pkt();
        send(8'h4B);
        send(8'h31);
        send(8'h32);
        send(8'h33);
        reset     = 1'b0;
        rx_active = 1'b0;
        tick();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_byte_count", int'(byte_count), 0);
        reset = 1'b1;
        repeat (5) tick();
        chk("midrst_no_done", done_cnt - b_done, 0);
        txq = '{8'hC3, 8'h00, 8'h00};
        run_pkt();
        chk("midrst_clean_ok", int'(f_ok), 1);

        // Length boundary: 1023 payload bytes allowed, 1024th flagged and not emitted
        txq = '{8'hC3};
        repeat (1023 + 2) txq.push_back(8'h00);
        run_pkt();
        chk("max_count", dv_cnt - b_dv, 1023);
        chk("max_len_err", int'(f_elen), 0);
        txq = '{8'hC3};
        repeat (1024 + 2) txq.push_back(8'h00);
        run_pkt();
        chk("over_count", dv_cnt - b_dv, 1023);
        chk("over_byte_count", f_bc, 1023);
        chk("over_len_err", int'(f_elen), 1);
        chk("over_ok", int'(f_ok), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
